// File: rtl/pipeline_stall_ctrl_if.sv
// Handshake bundle between the ID/EXE/MEM hazard sources and the stall controller.
// The master drives the requests and the slave returns the stall/flush/redirect controls.
interface pipeline_stall_ctrl_if #(
    parameter int PC_W  = 32,
    parameter int CNT_W = 32
);
    logic              stcl_lw;
    logic              stcl_jmp;
    logic              div_busy;
    logic              if_stall;
    logic              mem_stall;
    logic              exc_flush;
    logic [PC_W-1:0]   exc_pc;
    logic              cnt_clr;
    logic [4:0]        stall;
    logic [4:0]        flush;
    logic              redirect_valid;
    logic [PC_W-1:0]   redirect_pc;
    logic              div_cancel;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output stcl_lw, stcl_jmp, div_busy, if_stall, mem_stall,
               exc_flush, exc_pc, cnt_clr,
        input  stall, flush, redirect_valid, redirect_pc, div_cancel, stall_cnt
    );

    modport slave (
        input  stcl_lw, stcl_jmp, div_busy, if_stall, mem_stall,
               exc_flush, exc_pc, cnt_clr,
        output stall, flush, redirect_valid, redirect_pc, div_cancel, stall_cnt
    );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush generation for the 5-stage pipeline, exception redirect sequencing
// that waits out an outstanding AXI fetch, and a saturating stall-cycle counter.
//
// state    | meaning
// ---------+------------------------------------------------------------
// RUN      | normal operation, exception redirects issued next cycle
// WAIT_IF  | exception taken while a fetch is outstanding, holding PC
// REDIRECT | redirect pulse out, discarding the fetch that just returned
module pipeline_stall_ctrl #(
    parameter int CNT_W = 32,
    parameter int PC_W  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    pipeline_stall_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        WAIT_IF  = 2'd1,
        REDIRECT = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [PC_W-1:0]    pending_q, pending_d;
    logic               redirect_valid_q, redirect_valid_d;
    logic [PC_W-1:0]    redirect_pc_q, redirect_pc_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

    logic [4:0]         stall_norm, flush_norm;
    logic [4:0]         stall_c, flush_c;
    logic               div_cancel_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= RUN;
            pending_q        <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            stall_cnt_q      <= '0;
        end else begin
            state_q          <= state_d;
            pending_q        <= pending_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            stall_cnt_q      <= stall_cnt_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        pending_d        = pending_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        case (state_q)
            WAIT_IF: begin
                if (bus.exc_flush) pending_d = bus.exc_pc;
                if (!bus.if_stall) begin
                    state_d          = REDIRECT;
                    redirect_valid_d = 1'b1;
                    redirect_pc_d    = pending_d;
                end
            end
            default: begin
                state_d = RUN;
                if (bus.exc_flush && bus.if_stall) begin
                    pending_d = bus.exc_pc;
                    state_d   = WAIT_IF;
                end else if (bus.exc_flush) begin
                    redirect_valid_d = 1'b1;
                    redirect_pc_d    = bus.exc_pc;
                end
            end
        endcase
    end

    // Deepest requesting stage wins: hold it and everything upstream, bubble the next one.
    always_comb begin
        stall_norm = 5'b00000;
        flush_norm = 5'b00000;
        if (bus.mem_stall) begin
            stall_norm = 5'b01111;
            flush_norm = 5'b10000;
        end else if (bus.div_busy) begin
            stall_norm = 5'b00111;
            flush_norm = 5'b01000;
        end else if (bus.stcl_lw || bus.stcl_jmp) begin
            stall_norm = 5'b00011;
            flush_norm = 5'b00100;
        end else if (bus.if_stall) begin
            stall_norm = 5'b00001;
            flush_norm = 5'b00010;
        end
    end

    always_comb begin
        stall_c      = 5'b00000;
        flush_c      = 5'b00000;
        div_cancel_c = 1'b0;
        if (rst) begin
            stall_c      = 5'b00000;
        end else if (bus.exc_flush) begin
            stall_c      = {4'b0000, bus.if_stall};
            flush_c      = 5'b11110;
            div_cancel_c = 1'b1;
        end else begin
            stall_c = stall_norm;
            flush_c = flush_norm;
            if (state_q == WAIT_IF) begin
                stall_c[0] = 1'b1;
                stall_c[1] = 1'b0;
                flush_c[1] = 1'b1;
            end else if (state_q == REDIRECT) begin
                stall_c[1] = 1'b0;
                flush_c[1] = 1'b1;
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (bus.cnt_clr) begin
            stall_cnt_d = '0;
        end else if (stall_c[0] && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    assign bus.stall          = stall_c;
    assign bus.flush          = flush_c;
    assign bus.div_cancel     = div_cancel_c;
    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.stall_cnt      = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed and randomized checking of pipeline_stall_ctrl against a behavioural model
// that tracks "waiting for fetch" / "redirect due" as plain flags.
module tb_pipeline_stall_ctrl;

    localparam int PC_W  = 32;
    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic clk = 1'b0;
    logic rst = 1'b1;

    pipeline_stall_ctrl_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

    pipeline_stall_ctrl #(.CNT_W(CNT_W), .PC_W(PC_W)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    bit              m_wait;
    bit              m_redir;
    bit              m_rv;
    logic [PC_W-1:0] m_rpc;
    logic [PC_W-1:0] m_pend;
    int unsigned     m_cnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_wait  = 1'b0;
        m_redir = 1'b0;
        m_rv    = 1'b0;
        m_rpc   = '0;
        m_pend  = '0;
        m_cnt   = 0;
    endtask

    task automatic drive(input bit lw, input bit jmp, input bit dv, input bit ifs,
                         input bit mem, input bit exc, input logic [PC_W-1:0] pc, input bit clr);
        bus.stcl_lw   = lw;
        bus.stcl_jmp  = jmp;
        bus.div_busy  = dv;
        bus.if_stall  = ifs;
        bus.mem_stall = mem;
        bus.exc_flush = exc;
        bus.exc_pc    = pc;
        bus.cnt_clr   = clr;
    endtask

    // Called just after a rising edge; checks mid-cycle and advances the model.
    task automatic do_cycle(input bit lw, input bit jmp, input bit dv, input bit ifs,
                            input bit mem, input bit exc, input logic [PC_W-1:0] pc, input bit clr);
        int k;
        logic [4:0] e_st, e_fl;
        bit n_rv, n_redir;
        drive(lw, jmp, dv, ifs, mem, exc, pc, clr);
        #4;
        k = -1;
        if (mem)            k = 3;
        else if (dv)        k = 2;
        else if (lw || jmp) k = 1;
        else if (ifs)       k = 0;
        if (exc) begin
            e_st = {4'b0000, ifs};
            e_fl = 5'b11110;
        end else begin
            e_st = (k < 0) ? 5'd0 : 5'((1 << (k + 1)) - 1);
            e_fl = (k < 0) ? 5'd0 : 5'(1 << (k + 1));
            if (m_wait || m_redir) begin
                e_st[1] = 1'b0;
                e_fl[1] = 1'b1;
            end
            if (m_wait) e_st[0] = 1'b1;
        end
        check("stall", 64'(bus.stall), 64'(e_st));
        check("flush", 64'(bus.flush), 64'(e_fl));
        check("div_cancel", 64'(bus.div_cancel), 64'(exc));
        check("redirect_valid", 64'(bus.redirect_valid), 64'(m_rv));
        if (m_rv) check("redirect_pc", 64'(bus.redirect_pc), 64'(m_rpc));
        check("stall_cnt", 64'(bus.stall_cnt), 64'(m_cnt));

        n_rv    = 1'b0;
        n_redir = 1'b0;
        if (m_wait) begin
            if (exc) m_pend = pc;
            if (!ifs) begin
                n_rv    = 1'b1;
                m_rpc   = m_pend;
                n_redir = 1'b1;
                m_wait  = 1'b0;
            end
        end else if (exc) begin
            if (ifs) begin
                m_wait = 1'b1;
                m_pend = pc;
            end else begin
                n_rv  = 1'b1;
                m_rpc = pc;
            end
        end
        m_rv    = n_rv;
        m_redir = n_redir;
        if (clr)                             m_cnt = 0;
        else if (e_st[0] && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        do_cycle(0, 0, 0, 0, 0, 0, '0, 0);
    endtask

    // Asynchronous reset pulse mid-cycle with live inputs; everything must read zero.
    task automatic do_reset();
        drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), 1'b1,
              $urandom_range(0, 1), 1'b1, $urandom, 1'b0);
        rst = 1'b1;
        #2;
        check("rst_stall", 64'(bus.stall), 64'd0);
        check("rst_flush", 64'(bus.flush), 64'd0);
        check("rst_div_cancel", 64'(bus.div_cancel), 64'd0);
        check("rst_redirect_valid", 64'(bus.redirect_valid), 64'd0);
        check("rst_redirect_pc", 64'(bus.redirect_pc), 64'd0);
        check("rst_stall_cnt", 64'(bus.stall_cnt), 64'd0);
        model_reset();
        drive(0, 0, 0, 0, 0, 0, '0, 0);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit ifs_r;
        drive(0, 0, 0, 0, 0, 0, '0, 0);
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // load-use alone, then released
        do_cycle(1, 0, 0, 0, 0, 0, '0, 0);
        idle();
        check("cnt_after_lw", 64'(bus.stall_cnt), 64'd1);

        // deepest request dominates
        do_cycle(0, 1, 1, 0, 1, 0, '0, 0);

        // exception with no fetch outstanding
        do_cycle(0, 0, 0, 0, 0, 1, 32'hBFC0_0380, 0);
        idle();
        idle();

        // exception while a fetch is outstanding for three more cycles
        do_cycle(0, 0, 0, 1, 0, 1, 32'h8000_0180, 0);
        do_cycle(0, 0, 0, 1, 0, 0, '0, 0);
        do_cycle(1, 0, 0, 1, 0, 0, '0, 0);
        do_cycle(0, 0, 1, 1, 0, 0, '0, 0);
        do_cycle(0, 0, 0, 0, 0, 0, '0, 0);
        idle();
        idle();

        // second exception during WAIT_IF wins
        do_cycle(0, 0, 0, 1, 0, 1, 32'h8000_0180, 0);
        do_cycle(0, 0, 0, 1, 0, 1, 32'h8000_0200, 0);
        do_cycle(0, 0, 0, 1, 0, 0, '0, 0);
        do_cycle(0, 0, 0, 0, 0, 0, '0, 0);
        check("latest_pc", 64'(bus.redirect_pc), 64'h8000_0200);
        idle();

        // reset while waiting for the fetch drops the redirect
        do_cycle(0, 0, 0, 1, 0, 1, 32'h8000_0180, 0);
        do_cycle(0, 0, 0, 1, 0, 0, '0, 0);
        do_reset();
        for (int i = 0; i < 4; i++) idle();

        // counter saturation and clear
        for (int i = 0; i < int'(CNT_MAX) + 6; i++) do_cycle(0, 0, 0, 1, 0, 0, '0, 0);
        check("cnt_saturated", 64'(bus.stall_cnt), 64'(CNT_MAX));
        do_cycle(0, 0, 0, 1, 0, 0, '0, 1);
        check("cnt_cleared", 64'(bus.stall_cnt), 64'd0);
        idle();

        // randomized traffic
        ifs_r = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) ifs_r = ~ifs_r;
            if ($urandom_range(0, 400) == 0) begin
                do_reset();
            end else begin
                do_cycle($urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
                         $urandom_range(0, 5) == 0, ifs_r, $urandom_range(0, 6) == 0,
                         $urandom_range(0, 7) == 0, $urandom, $urandom_range(0, 60) == 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
